// File: rtl/gshare_branch_pred_pkg.sv
// Shared types for the branch predictor slice: the core-facing request,
// response and feedback records, plus the predictor's own FSM state type.

package core;

    localparam int peval_width  = 2;
    localparam int bp_hist_bits = 6;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } branch_pred_req_t;

    typedef struct packed {
        logic                    taken;
        logic                    eval_alt;
        logic [bp_hist_bits-1:0] hist;
    } branch_pred_rsp_t;

    typedef struct packed {
        logic                    valid;
        logic [31:0]             pc;
        logic [bp_hist_bits-1:0] hist;
        logic                    taken;
        logic                    mispred;
    } branch_pred_fb_t;

endpackage

package gshare_branch_pred_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } pred_state_t;

endpackage

// File: rtl/gshare_branch_pred_entry_update.sv
// Combinational training step for one predictor entry: saturating direction
// counter plus a confidence counter that grows while the counter agrees with
// the outcome and collapses to zero on disagreement.

module pred_entry_update
    import gshare_branch_pred_pkg::*;
#(
    parameter int CTR_BITS  = 2,
    parameter int CONF_BITS = 2
) (
    input  logic [CTR_BITS-1:0]  ctr_in,
    input  logic [CONF_BITS-1:0] conf_in,
    input  logic                 taken,
    output logic [CTR_BITS-1:0]  ctr_out,
    output logic [CONF_BITS-1:0] conf_out
);

    // Move the counter one step toward the outcome and rate the old prediction.
    always_comb begin
        ctr_out  = ctr_in;
        conf_out = '0;
        if (taken) begin
            if (ctr_in != '1) ctr_out = ctr_in + 1'b1;
        end else begin
            if (ctr_in != '0) ctr_out = ctr_in - 1'b1;
        end
        if (ctr_in[CTR_BITS-1] == taken) begin
            conf_out = (conf_in == '1) ? conf_in : conf_in + 1'b1;
        end
    end

endmodule

// File: rtl/gshare_branch_pred.sv
// Multi-slot gshare predictor. Lookups are combinational against the table
// and the speculative global history; resolved branches train one entry per
// cycle and a mispredict rewrites the history from the branch's own snapshot.
// After reset the table is cleared one entry per cycle before going live.

module gshare_branch_pred
    import gshare_branch_pred_pkg::*;
#(
    parameter int PORTS       = core::peval_width,
    parameter int TABLE_SIZE  = 64,
    parameter int HIST_BITS   = 6,
    parameter int CTR_BITS    = 2,
    parameter int CONF_BITS   = 2,
    parameter int CONF_THRESH = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    output logic                              ready,
    input  logic [PORTS-1:0]                  req_valid,
    input  logic [PORTS-1:0][31:0]            req_pc,
    output logic [PORTS-1:0]                  rsp_taken,
    output logic [PORTS-1:0]                  rsp_eval_alt,
    output logic [PORTS-1:0][HIST_BITS-1:0]   rsp_hist,
    input  logic                              fb_valid,
    input  logic [31:0]                       fb_pc,
    input  logic [HIST_BITS-1:0]              fb_hist,
    input  logic                              fb_taken,
    input  logic                              fb_mispred
);

    localparam int IDX = $clog2(TABLE_SIZE);

    typedef logic [IDX-1:0]       idx_t;
    typedef logic [HIST_BITS-1:0] hist_t;
    typedef struct packed {
        logic [CTR_BITS-1:0]  ctr;
        logic [CONF_BITS-1:0] conf;
    } entry_t;

    localparam logic [CTR_BITS-1:0]  CTR_INIT   = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CONF_BITS-1:0] CONF_TH    = CONF_BITS'(CONF_THRESH);
    localparam entry_t               ENTRY_INIT = '{ctr: CTR_INIT, conf: '0};

    pred_state_t state, state_next;
    idx_t        sweep_idx;
    hist_t       ghr, ghr_next, spec_hist;
    entry_t      table_q [TABLE_SIZE];

    idx_t                 fb_idx;
    entry_t               fb_old;
    logic [CTR_BITS-1:0]  upd_ctr;
    logic [CONF_BITS-1:0] upd_conf;
    logic                 unused_pc_bits;

    // Only the word-index bits of the PCs feed the hash.
    assign unused_pc_bits = ^{req_pc, fb_pc};

    assign ready  = (state == RUN);
    assign fb_idx = fb_pc[IDX+1:2] ^ idx_t'(fb_hist);
    assign fb_old = table_q[fb_idx];

    pred_entry_update #(
        .CTR_BITS  (CTR_BITS),
        .CONF_BITS (CONF_BITS)
    ) u_entry_update (
        .ctr_in   (fb_old.ctr),
        .conf_in  (fb_old.conf),
        .taken    (fb_taken),
        .ctr_out  (upd_ctr),
        .conf_out (upd_conf)
    );

    // Per-slot lookup; each valid slot pushes its own prediction into the history seen by later slots.
    always_comb begin
        idx_t   lk_idx;
        entry_t lk_entry;
        lk_idx       = '0;
        lk_entry     = '0;
        spec_hist    = ghr;
        rsp_taken    = '0;
        rsp_eval_alt = '0;
        rsp_hist     = '0;
        for (int i = 0; i < PORTS; i++) begin
            lk_idx   = req_pc[i][IDX+1:2] ^ idx_t'(spec_hist);
            lk_entry = table_q[lk_idx];
            if (state == RUN) begin
                rsp_taken[i]    = lk_entry.ctr[CTR_BITS-1];
                rsp_eval_alt[i] = (lk_entry.conf < CONF_TH);
                rsp_hist[i]     = spec_hist;
                if (req_valid[i]) begin
                    spec_hist = {spec_hist[HIST_BITS-2:0], lk_entry.ctr[CTR_BITS-1]};
                end
            end
        end
    end

    // Next state and next history; a mispredict repair overrides speculative shifting.
    always_comb begin
        state_next = state;
        ghr_next   = ghr;
        case (state)
            INIT: begin
                ghr_next = '0;
                if (sweep_idx == idx_t'(TABLE_SIZE - 1)) state_next = RUN;
            end
            RUN: begin
                if (en) begin
                    ghr_next = spec_hist;
                    if (fb_valid && fb_mispred) ghr_next = {fb_hist[HIST_BITS-2:0], fb_taken};
                end
            end
            default: state_next = INIT;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_next;
    end

    // History and sweep pointer; the sweep advances regardless of enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_idx <= '0;
            ghr       <= '0;
        end else begin
            ghr <= ghr_next;
            if (state == INIT) sweep_idx <= sweep_idx + 1'b1;
        end
    end

    // Table writes: clearing during the sweep, training once live.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                table_q[sweep_idx] <= ENTRY_INIT;
            end else if (en && fb_valid) begin
                table_q[fb_idx] <= '{ctr: upd_ctr, conf: upd_conf};
            end
        end
    end

endmodule

// File: tb/tb_gshare_branch_pred.sv
// Self-checking bench for gshare_branch_pred with default parameters.
// Expected values are queued when stimulus is applied and popped as the
// design's responses are sampled, half a cycle away from the rising edge.

module tb_gshare_branch_pred;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             ready;
    logic [1:0]       req_valid;
    logic [1:0][31:0] req_pc;
    logic [1:0]       rsp_taken;
    logic [1:0]       rsp_eval_alt;
    logic [1:0][5:0]  rsp_hist;
    logic             fb_valid;
    logic [31:0]      fb_pc;
    logic [5:0]       fb_hist;
    logic             fb_taken;
    logic             fb_mispred;

    int passed = 0;
    int total  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs;
    logic [31:0] expv;

    gshare_branch_pred dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .ready        (ready),
        .req_valid    (req_valid),
        .req_pc       (req_pc),
        .rsp_taken    (rsp_taken),
        .rsp_eval_alt (rsp_eval_alt),
        .rsp_hist     (rsp_hist),
        .fb_valid     (fb_valid),
        .fb_pc        (fb_pc),
        .fb_hist      (fb_hist),
        .fb_taken     (fb_taken),
        .fb_mispred   (fb_mispred)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic idle();
        req_valid  = '0;
        req_pc     = '0;
        fb_valid   = 1'b0;
        fb_pc      = '0;
        fb_hist    = '0;
        fb_taken   = 1'b0;
        fb_mispred = 1'b0;
        en         = 1'b1;
    endtask

    // Sweep after a one-cycle reset with traffic present that must be ignored.
    task automatic test_reset();
        @(negedge clk);
        rst        = 1'b1;
        req_valid  = 2'b11;
        req_pc[0]  = 32'h100;
        req_pc[1]  = 32'h44;
        fb_valid   = 1'b1;
        fb_mispred = 1'b1;
        fb_hist    = 6'b101010;
        fb_taken   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 64; c++) exp_q.push_back(32'h0);
        exp_q.push_back({15'b0, 1'b1, 2'b00, 2'b11, 6'd0, 6'd0});
        for (int c = 0; c <= 64; c++) begin
            #1;
            obs  = {15'b0, ready, rsp_taken, rsp_eval_alt, rsp_hist[1], rsp_hist[0]};
            expv = pop_exp();
            total++;
            if (obs !== expv) $display("[TB] FAIL reset_sweep[%0d]: observed %0h expected %0h", c, obs, expv);
            else passed++;
            if (c < 64) @(negedge clk);
        end
        idle();
    endtask

    // Taken, taken, not-taken at one entry; each sample precedes its training edge.
    task automatic test_hysteresis();
        logic [2:0] seq;
        seq = 3'b011;
        @(negedge clk);
        idle();
        req_pc[0] = 32'h100;
        fb_pc     = 32'h100;
        fb_valid  = 1'b1;
        exp_q.push_back(32'b01);
        exp_q.push_back(32'b11);
        exp_q.push_back(32'b11);
        exp_q.push_back(32'b11);
        for (int k = 0; k < 4; k++) begin
            if (k < 3) fb_taken = seq[k];
            else       fb_valid = 1'b0;
            #1;
            obs  = {30'b0, rsp_taken[0], rsp_eval_alt[0]};
            expv = pop_exp();
            total++;
            if (obs !== expv) $display("[TB] FAIL hysteresis[%0d]: observed %0h expected %0h", k, obs, expv);
            else passed++;
            @(negedge clk);
        end
    endtask

    // Five taken then one not-taken: confidence climbs, saturates, then collapses.
    task automatic test_confidence();
        logic [5:0] seq;
        seq = 6'b011111;
        idle();
        req_pc[0] = 32'h40;
        fb_pc     = 32'h40;
        fb_valid  = 1'b1;
        exp_q.push_back(32'b01);
        exp_q.push_back(32'b11);
        exp_q.push_back(32'b11);
        exp_q.push_back(32'b11);
        exp_q.push_back(32'b10);
        exp_q.push_back(32'b10);
        exp_q.push_back(32'b11);
        for (int k = 0; k < 7; k++) begin
            if (k < 6) fb_taken = seq[k];
            else       fb_valid = 1'b0;
            #1;
            obs  = {30'b0, rsp_taken[0], rsp_eval_alt[0]};
            expv = pop_exp();
            total++;
            if (obs !== expv) $display("[TB] FAIL confidence[%0d]: observed %0h expected %0h", k, obs, expv);
            else passed++;
            @(negedge clk);
        end
    endtask

    // Slot-ordered speculative history, enable gating and invalid slots.
    task automatic test_spec_history();
        idle();
        req_valid = 2'b11;
        req_pc[0] = 32'h100;
        req_pc[1] = 32'h44;
        exp_q.push_back({20'b0, 2'b11, 6'd1, 6'd0});
        #1;
        obs  = {20'b0, rsp_taken, rsp_hist[1], rsp_hist[0]};
        expv = pop_exp();
        total++;
        if (obs !== expv) $display("[TB] FAIL spec_lookup: observed %0h expected %0h", obs, expv);
        else passed++;

        @(negedge clk);
        en        = 1'b0;
        req_valid = 2'b01;
        req_pc[0] = 32'h100;
        fb_valid  = 1'b1;
        fb_pc     = 32'h100;
        fb_hist   = 6'd0;
        fb_taken  = 1'b0;
        exp_q.push_back({20'b0, 6'd6, 6'd3});
        #1;
        obs  = {20'b0, rsp_hist[1], rsp_hist[0]};
        expv = pop_exp();
        total++;
        if (obs !== expv) $display("[TB] FAIL spec_ghr_update: observed %0h expected %0h", obs, expv);
        else passed++;

        @(negedge clk);
        idle();
        req_valid = 2'b10;
        req_pc[0] = 32'h100;
        req_pc[1] = 32'h44;
        exp_q.push_back({20'b0, 6'd3, 6'd3});
        #1;
        obs  = {20'b0, rsp_hist[1], rsp_hist[0]};
        expv = pop_exp();
        total++;
        if (obs !== expv) $display("[TB] FAIL enable_hold_invalid_slot: observed %0h expected %0h", obs, expv);
        else passed++;

        @(negedge clk);
        idle();
        req_pc[0] = 32'h18;
        exp_q.push_back({25'b0, 1'b1, 6'd6});
        #1;
        obs  = {25'b0, rsp_taken[0], rsp_hist[0]};
        expv = pop_exp();
        total++;
        if (obs !== expv) $display("[TB] FAIL slot1_shift_no_train_when_disabled: observed %0h expected %0h", obs, expv);
        else passed++;
        @(negedge clk);
    endtask

    // Mispredict repair beats request shifting in the same cycle.
    task automatic test_repair();
        idle();
        req_valid  = 2'b11;
        req_pc[0]  = 32'h100;
        req_pc[1]  = 32'h44;
        fb_valid   = 1'b1;
        fb_mispred = 1'b1;
        fb_pc      = 32'h0;
        fb_hist    = 6'b101010;
        fb_taken   = 1'b1;
        @(negedge clk);
        idle();
        req_pc[0] = 32'hFC;
        exp_q.push_back({24'b0, 1'b1, 1'b1, 6'b010101});
        #1;
        obs  = {24'b0, rsp_taken[0], rsp_eval_alt[0], rsp_hist[0]};
        expv = pop_exp();
        total++;
        if (obs !== expv) $display("[TB] FAIL repair_ghr_and_train: observed %0h expected %0h", obs, expv);
        else passed++;
        @(negedge clk);
    endtask

    // A second reset at cycle 30 of a sweep restarts the full sweep and clears history.
    task automatic test_mid_sweep_reset();
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 30; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        req_pc[0] = 32'h100;
        for (int c = 0; c < 64; c++) exp_q.push_back(32'h0);
        exp_q.push_back({24'b0, 1'b1, 1'b0, 6'd0});
        for (int c = 0; c <= 64; c++) begin
            #1;
            obs  = {24'b0, ready, rsp_taken[0], rsp_hist[0]};
            expv = pop_exp();
            total++;
            if (obs !== expv) $display("[TB] FAIL mid_sweep_reset[%0d]: observed %0h expected %0h", c, obs, expv);
            else passed++;
            if (c < 64) @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1'b0;
        test_reset();
        test_hysteresis();
        test_confidence();
        test_spec_history();
        test_repair();
        test_mid_sweep_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
